tsip_tx_scheduler: RTL and testbench



---
 rtl/tsip_tx_scheduler.sv | 242 ++++++++++++++++++++++++
 tb/tb_tsip_tx_scheduler.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tsip_tx_scheduler.sv
// Round-robin scheduler that frames requester commands as TSIP packets
// (DLE, ID, stuffed payload, DLE, ETX) and paces them into a shared uart_tx.
module tsip_tx_scheduler #(
    parameter int N_REQ    = 2,
    parameter int LEN_W    = 4,
    parameter int GAP_CLKS = 10417
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [N_REQ-1:0]       i_req,
    input  logic [8*N_REQ-1:0]     i_id,
    input  logic [LEN_W*N_REQ-1:0] i_len,
    input  logic [8*N_REQ-1:0]     i_pl_byte,
    output logic [LEN_W-1:0]       o_pl_idx,
    output logic [N_REQ-1:0]       o_grant,
    output logic [N_REQ-1:0]       o_done,
    output logic                   o_busy,
    output logic                   o_tx_dv,
    output logic [7:0]             o_tx_byte,
    input  logic                   i_tx_done
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GAP_W = $clog2(GAP_CLKS + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT, S_NEXT, S_GAP} state_t;
    typedef enum logic [2:0] {P_HDR, P_ID, P_PL, P_STUFF, P_TRL, P_ETX} phase_t;

    state_t             state_q, state_d;
    phase_t             phase_q, phase_d;
    phase_t             ret_phase_q, ret_phase_d;
    logic               ret_inc_q, ret_inc_d;
    logic [PTR_W-1:0]   owner_q, owner_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [7:0]         id_q, id_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   pl_idx_q, pl_idx_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic [7:0]         tx_byte_q, tx_byte_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;

    logic [7:0]         id_arr_s  [N_REQ];
    logic [LEN_W-1:0]   len_arr_s [N_REQ];
    logic [7:0]         pl_arr_s  [N_REQ];
    logic [7:0]         byte_s;
    phase_t             adv_phase_s;
    logic               adv_inc_s;
    logic [PTR_W-1:0]   winner_s;

    // First requesting index at or after ptr, searching upward with wrap.
    function automatic logic [PTR_W-1:0] pick_winner(input logic [N_REQ-1:0] req,
                                                     input logic [PTR_W-1:0] ptr);
        logic [PTR_W-1:0] cand;
        logic [PTR_W-1:0] win;
        logic             found;
        cand  = ptr;
        win   = ptr;
        found = 1'b0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && req[cand]) begin
                win   = cand;
                found = 1'b1;
            end else begin
                win   = win;
            end
            cand = (cand == PTR_W'(N_REQ - 1)) ? PTR_W'(0) : cand + PTR_W'(1);
        end
        return win;
    endfunction

    function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Split the packed per-requester buses into indexable arrays.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            id_arr_s[k]  = i_id[8*k +: 8];
            len_arr_s[k] = i_len[LEN_W*k +: LEN_W];
            pl_arr_s[k]  = i_pl_byte[8*k +: 8];
        end
    end

    // Byte for the current phase; the payload is sampled live in SEND.
    always_comb begin
        case (phase_q)
            P_HDR:   byte_s = 8'h10;
            P_ID:    byte_s = id_q;
            P_PL:    byte_s = pl_arr_s[owner_q];
            P_STUFF: byte_s = 8'h10;
            P_TRL:   byte_s = 8'h10;
            P_ETX:   byte_s = 8'h03;
            default: byte_s = 8'h00;
        endcase
    end

    // Phase that follows the ID or a payload byte, ignoring any stuffing.
    always_comb begin
        adv_phase_s = P_TRL;
        adv_inc_s   = 1'b0;
        if (phase_q == P_ID) begin
            adv_phase_s = (len_q == LEN_W'(0)) ? P_TRL : P_PL;
        end else if (pl_idx_q != len_q - LEN_W'(1)) begin
            adv_phase_s = P_PL;
            adv_inc_s   = 1'b1;
        end else begin
            adv_phase_s = P_TRL;
        end
    end

    assign winner_s = pick_winner(i_req, ptr_q);

    // Scheduler next-state: arbitration, framing and byte pacing.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        ret_phase_d = ret_phase_q;
        ret_inc_d   = ret_inc_q;
        owner_d     = owner_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        len_d       = len_q;
        pl_idx_d    = pl_idx_q;
        grant_d     = grant_q;
        done_d      = '0;
        tx_byte_d   = tx_byte_q;
        gap_cnt_d   = gap_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (|i_req) begin
                    owner_d = winner_s;
                    grant_d = onehot(winner_s);
                    state_d = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                id_d     = id_arr_s[owner_q];
                len_d    = len_arr_s[owner_q];
                phase_d  = P_HDR;
                pl_idx_d = '0;
                state_d  = S_SEND;
            end
            S_SEND: begin
                tx_byte_d = byte_s;
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (i_tx_done) begin
                    state_d = S_NEXT;
                    done_d  = (phase_q == P_ETX) ? onehot(owner_q) : '0;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_NEXT: begin
                if (phase_q == P_ETX) begin
                    state_d   = S_GAP;
                    grant_d   = '0;
                    gap_cnt_d = '0;
                    ptr_d     = (owner_q == PTR_W'(N_REQ - 1)) ? PTR_W'(0) : owner_q + PTR_W'(1);
                end else begin
                    state_d = S_SEND;
                    case (phase_q)
                        P_HDR: phase_d = P_ID;
                        P_ID, P_PL: begin
                            if (tx_byte_q == 8'h10) begin
                                phase_d     = P_STUFF;
                                ret_phase_d = adv_phase_s;
                                ret_inc_d   = adv_inc_s;
                            end else begin
                                phase_d  = adv_phase_s;
                                pl_idx_d = pl_idx_q + LEN_W'(adv_inc_s);
                            end
                        end
                        P_STUFF: begin
                            phase_d  = ret_phase_q;
                            pl_idx_d = pl_idx_q + LEN_W'(ret_inc_q);
                        end
                        P_TRL:   phase_d = P_ETX;
                        default: phase_d = P_HDR;
                    endcase
                end
            end
            S_GAP: begin
                if (gap_cnt_q == GAP_W'(GAP_CLKS - 1)) begin
                    state_d = S_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; reset aborts any packet in flight.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            phase_q     <= P_HDR;
            ret_phase_q <= P_HDR;
            ret_inc_q   <= 1'b0;
            owner_q     <= '0;
            ptr_q       <= '0;
            id_q        <= 8'h00;
            len_q       <= '0;
            pl_idx_q    <= '0;
            grant_q     <= '0;
            done_q      <= '0;
            tx_byte_q   <= 8'h00;
            gap_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            ret_phase_q <= ret_phase_d;
            ret_inc_q   <= ret_inc_d;
            owner_q     <= owner_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            len_q       <= len_d;
            pl_idx_q    <= pl_idx_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            tx_byte_q   <= tx_byte_d;
            gap_cnt_q   <= gap_cnt_d;
        end
    end

    assign o_grant   = grant_q;
    assign o_done    = done_q;
    assign o_pl_idx  = pl_idx_q;
    assign o_busy    = (state_q != S_IDLE);
    assign o_tx_dv   = (state_q == S_SEND);
    // In SEND the live byte is presented; afterwards the latched copy holds it.
    assign o_tx_byte = (state_q == S_SEND) ? byte_s : tx_byte_q;

endmodule

// File: tb/tb_tsip_tx_scheduler.sv
// Scoreboard bench for tsip_tx_scheduler: packets predicted from the framing
// and round-robin rules, checked by a monitor as bytes leave the DUT.
module tb_tsip_tx_scheduler;
    localparam int N_REQ    = 2;
    localparam int LEN_W    = 4;
    localparam int GAP_CLKS = 20;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_REQ-1:0]       i_req;
    logic [8*N_REQ-1:0]     i_id;
    logic [LEN_W*N_REQ-1:0] i_len;
    logic [8*N_REQ-1:0]     i_pl_byte;
    logic [LEN_W-1:0]       o_pl_idx;
    logic [N_REQ-1:0]       o_grant;
    logic [N_REQ-1:0]       o_done;
    logic                   o_busy;
    logic                   o_tx_dv;
    logic [7:0]             o_tx_byte;
    logic                   i_tx_done;

    tsip_tx_scheduler #(.N_REQ(N_REQ), .LEN_W(LEN_W), .GAP_CLKS(GAP_CLKS)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .i_id(i_id), .i_len(i_len),
        .i_pl_byte(i_pl_byte), .o_pl_idx(o_pl_idx), .o_grant(o_grant), .o_done(o_done),
        .o_busy(o_busy), .o_tx_dv(o_tx_dv), .o_tx_byte(o_tx_byte), .i_tx_done(i_tx_done)
    );

    always #5 clk = ~clk;

    logic [7:0] rq_id [N_REQ];
    int         rq_len[N_REQ];
    logic [7:0] rq_pl [N_REQ][16];

    // Requester models: payload byte served combinationally at o_pl_idx.
    always_comb begin
        for (int k = 0; k < N_REQ; k++) begin
            i_id[8*k +: 8]          = rq_id[k];
            i_len[LEN_W*k +: LEN_W] = LEN_W'(rq_len[k]);
            i_pl_byte[8*k +: 8]     = rq_pl[k][o_pl_idx];
        end
    end

    int  n_checks = 0;
    int  n_fail   = 0;
    int  done_cnt = 0;
    int  rr_ptr   = 0;
    bit  spur_en  = 1'b0;
    logic txd_at_edge = 1'b0;

    logic [7:0]       exp_b[$];
    logic [N_REQ-1:0] exp_g[$];
    int               exp_lim[$];
    logic [N_REQ-1:0] exp_d[$];

    always @(posedge clk) txd_at_edge <= i_tx_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired or nothing queued (t=%0t)", name, $time);
    endtask

    function automatic int rr_pick(input logic [N_REQ-1:0] set, input int ptr);
        for (int j = 0; j < N_REQ; j++) begin
            if (set[(ptr + j) % N_REQ]) return (ptr + j) % N_REQ;
        end
        return 0;
    endfunction

    task automatic push_byte(input logic [7:0] b, input logic [N_REQ-1:0] g, input int lim);
        exp_b.push_back(b);
        exp_g.push_back(g);
        exp_lim.push_back(lim);
    endtask

    // Expected TSIP frame for requester k from its current contents.
    task automatic push_pkt(input int k);
        logic [N_REQ-1:0] g;
        int lim;
        g    = '0;
        g[k] = 1'b1;
        lim  = (rq_len[k] == 0) ? 0 : rq_len[k] - 1;
        push_byte(8'h10, g, lim);
        push_byte(rq_id[k], g, lim);
        if (rq_id[k] == 8'h10) push_byte(8'h10, g, lim);
        for (int i = 0; i < rq_len[k]; i++) begin
            push_byte(rq_pl[k][i], g, lim);
            if (rq_pl[k][i] == 8'h10) push_byte(8'h10, g, lim);
        end
        push_byte(8'h10, g, lim);
        push_byte(8'h03, g, lim);
        exp_d.push_back(g);
    endtask

    task automatic set_rq(input int k, input logic [7:0] id, input int len,
                          input logic [39:0] pl5);
        logic [39:0] p;
        p = pl5;
        rq_id[k]  = id;
        rq_len[k] = len;
        for (int i = 0; i < 16; i++) rq_pl[k][i] = (i < 5) ? p[39-8*i -: 8] : 8'h00;
    endtask

    task automatic rand_rq(input int k);
        rq_id[k]  = ($urandom_range(3, 0) == 0) ? 8'h10 : 8'($urandom);
        rq_len[k] = $urandom_range(15, 0);
        for (int i = 0; i < 16; i++)
            rq_pl[k][i] = ($urandom_range(3, 0) == 0) ? 8'h10 : 8'($urandom);
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (o_busy && t < 5000) begin
            @(negedge clk);
            t++;
        end
        if (o_busy) bound_fail("wait_idle");
    endtask

    // Each requester in set asks once; mode 1 checks latency, mode 2 drops early.
    task automatic run_once(input logic [N_REQ-1:0] set, input int mode);
        logic [N_REQ-1:0] pend;
        int w, target, t;
        wait_idle();
        pend   = set;
        target = done_cnt;
        while (pend != '0) begin
            w = rr_pick(pend, rr_ptr);
            push_pkt(w);
            pend[w] = 1'b0;
            rr_ptr  = (w + 1) % N_REQ;
            target++;
        end
        i_req = set;
        if (mode != 0) begin
            @(negedge clk);
            if (mode == 1) begin
                chk("lat_grant", 32'(o_grant), 32'(set));
                chk("lat_busy", 32'(o_busy), 32'd1);
                chk("lat_dv_not_yet", 32'(o_tx_dv), 32'd0);
                @(negedge clk);
                chk("lat_first_dv", 32'(o_tx_dv), 32'd1);
            end else begin
                i_req = '0;
            end
        end
        t = 0;
        while (done_cnt < target && t < 5000) begin
            @(negedge clk);
            i_req = i_req & ~o_done;
            t++;
        end
        if (done_cnt < target) bound_fail("run_once_done");
        i_req = '0;
    endtask

    // Requesters in set hold i_req continuously for n packets.
    task automatic run_held(input logic [N_REQ-1:0] set, input int n);
        int w, target, t;
        wait_idle();
        target = done_cnt + n;
        for (int i = 0; i < n; i++) begin
            w = rr_pick(set, rr_ptr);
            push_pkt(w);
            rr_ptr = (w + 1) % N_REQ;
        end
        i_req = set;
        t = 0;
        while (done_cnt < target && t < 20000) begin
            @(negedge clk);
            t++;
        end
        if (done_cnt < target) bound_fail("run_held_done");
        i_req = '0;
    endtask

    // UART model: done 1..4 cycles after each strobe, optional spurious pulses.
    initial begin : uart_model
        int cnt;
        bit inflight;
        i_tx_done = 1'b0;
        inflight  = 1'b0;
        cnt       = 0;
        forever begin
            @(negedge clk);
            i_tx_done = 1'b0;
            if (!rst_n) begin
                inflight = 1'b0;
            end else if (inflight) begin
                if (cnt == 0) begin
                    i_tx_done = 1'b1;
                    inflight  = 1'b0;
                end else begin
                    cnt--;
                end
            end else if (o_tx_dv) begin
                inflight = 1'b1;
                cnt      = $urandom_range(3, 0);
            end else if (spur_en && $urandom_range(4, 0) == 0) begin
                i_tx_done = 1'b1;
            end
        end
    end

    // Monitor: pops the scoreboard on every strobe and done pulse.
    initial begin : monitor
        int gap_run;
        logic [7:0] eb;
        logic [N_REQ-1:0] eg;
        int el;
        gap_run = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                gap_run = 0;
            end else begin
                if (o_tx_dv) begin
                    if (exp_b.size() == 0) begin
                        bound_fail("unexpected_tx_byte");
                    end else begin
                        eb = exp_b.pop_front();
                        eg = exp_g.pop_front();
                        el = exp_lim.pop_front();
                        chk("tx_byte", 32'(o_tx_byte), 32'(eb));
                        chk("grant_at_tx", 32'(o_grant), 32'(eg));
                        chk("pl_idx_bound", 32'(int'(o_pl_idx) <= el), 32'd1);
                    end
                end
                if (o_done != '0) begin
                    if (exp_d.size() == 0) begin
                        bound_fail("unexpected_done");
                    end else begin
                        chk("done_owner", 32'(o_done), 32'(exp_d.pop_front()));
                        chk("done_after_etx", 32'(txd_at_edge), 32'd1);
                    end
                    done_cnt++;
                end
                if (o_busy && o_grant == '0) begin
                    gap_run++;
                end else if (gap_run != 0) begin
                    chk("gap_len", 32'(gap_run), 32'(GAP_CLKS));
                    gap_run = 0;
                end
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_grant"}, 32'(o_grant), 32'd0);
        chk({tag, "_done"}, 32'(o_done), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_tx_dv"}, 32'(o_tx_dv), 32'd0);
        chk({tag, "_tx_byte"}, 32'(o_tx_byte), 32'd0);
        chk({tag, "_pl_idx"}, 32'(o_pl_idx), 32'd0);
    endtask

    initial begin : stimulus
        int t;
        rst_n = 1'b0;
        i_req = '0;
        for (int k = 0; k < N_REQ; k++) set_rq(k, 8'h00, 0, 40'h0);
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous requests from reset, then the pointer wraps back to 0.
        set_rq(0, 8'h21, 1, 40'h5500000000);
        set_rq(1, 8'h22, 2, 40'h6677000000);
        run_once(2'b11, 0);
        run_once(2'b11, 0);
        run_held(2'b11, 4);

        // Single requester, latency and basic frame.
        set_rq(0, 8'h8E, 2, 40'hA201000000);
        run_once(2'b01, 1);

        // Payload stuffing.
        set_rq(1, 8'h8E, 5, 40'hA500100000);
        run_once(2'b10, 0);

        // Empty payload with a stuffed ID.
        set_rq(0, 8'h10, 0, 40'h0);
        run_once(2'b01, 0);

        // Early request drop and spurious done pulses.
        spur_en = 1'b1;
        set_rq(1, 8'h31, 3, 40'h0102030000);
        run_once(2'b10, 2);

        for (int r = 0; r < 20; r++) begin
            rand_rq(0);
            rand_rq(1);
            run_once(N_REQ'($urandom_range(3, 1)), 0);
        end
        spur_en = 1'b0;

        // Asynchronous reset mid-payload.
        wait_idle();
        set_rq(1, 8'h55, 6, 40'h1122334455);
        push_pkt(1);
        i_req = 2'b10;
        t = 0;
        while (!(o_tx_dv && o_pl_idx == LEN_W'(2)) && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 2000) bound_fail("reach_mid_payload");
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        exp_b.delete();
        exp_g.delete();
        exp_lim.delete();
        exp_d.delete();
        rr_ptr = 0;
        i_req  = '0;
        @(negedge clk);
        rst_n = 1'b1;
        set_rq(0, 8'h41, 2, 40'h1010000000);
        set_rq(1, 8'h42, 1, 40'h9900000000);
        run_once(2'b11, 0);

        wait_idle();
        repeat (3) @(negedge clk);
        chk("exp_bytes_drained", 32'(exp_b.size()), 32'd0);
        chk("exp_done_drained", 32'(exp_d.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
